// File: rtl/gate_id_pkg.sv
// gate_id_pkg: shared types and constants for the gate identifier.
//   gate_e      - 3-bit code for the decoded two-input gate function
//   TT_*        - 4-bit truth tables; bit i is the gate output for {a,b} = i
//   state_e     - characterisation FSM states
package gate_id_pkg;

   localparam int GATE_W = 3;

   typedef enum logic [GATE_W-1:0] {
      GATE_NONE = 3'd0,
      GATE_OR   = 3'd1,
      GATE_AND  = 3'd2,
      GATE_NOTA = 3'd3,
      GATE_NAND = 3'd4,
      GATE_NOR  = 3'd5,
      GATE_XOR  = 3'd6,
      GATE_XNOR = 3'd7
   } gate_e;

   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_NOTA = 4'b0011;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/gate_identifier_decode.sv
// gate_tt_decode: combinational map from a captured 4-entry truth table to
// a library gate code.
//   tt_i       [3:0]  truth table, bit i = output for {a,b} = i
//   match_o           1 when tt_i equals one of the seven library gates
//   gate_id_o  [2:0]  gate code, GATE_NONE when there is no match
module gate_tt_decode
   import gate_id_pkg::*;
(
   input  logic [3:0] tt_i,
   output logic       match_o,
   output gate_e      gate_id_o
);

   always_comb begin
      match_o   = 1'b1;
      gate_id_o = GATE_NONE;
      case (tt_i)
         TT_OR:   gate_id_o = GATE_OR;
         TT_AND:  gate_id_o = GATE_AND;
         TT_NOTA: gate_id_o = GATE_NOTA;
         TT_NAND: gate_id_o = GATE_NAND;
         TT_NOR:  gate_id_o = GATE_NOR;
         TT_XOR:  gate_id_o = GATE_XOR;
         TT_XNOR: gate_id_o = GATE_XNOR;
         default: match_o   = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_identifier.sv
// gate_identifier: drives the four input vectors into an unknown two-input
// gate, samples its output after a settle window, and decodes the captured
// truth table to a library gate code.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle run request, ignored while busy
//   gut_y        output of the gate under test
//   drive_a/b    registered GUT inputs, {a,b} = vector index
//   busy         run in progress
//   done         one-cycle pulse, results valid from here on
//   match        truth table equals a library gate
//   gate_id      decoded gate code (0 = none)
//   truth_table  captured outputs, bit i = gut_y for {a,b} = i
//
// Build option: define GATE_ID_SYNC_EN to pass gut_y through a 2-flop
// synchroniser; each settle window then grows by two cycles.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; results from the last run held
// ST_SETTLE  | current vector driven, waiting for the GUT output to settle
// ST_SAMPLE  | capture gut_y into truth_table[idx], advance vector
// ST_DONE    | publish decoded result, pulse done, drop busy
module gate_identifier
   import gate_id_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned GATE_W        = 3
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              gut_y,
   output logic              drive_a,
   output logic              drive_b,
   output logic              busy,
   output logic              done,
   output logic              match,
   output logic [GATE_W-1:0] gate_id,
   output logic [3:0]        truth_table
);

`ifdef GATE_ID_SYNC_EN
   localparam int unsigned SYNC_EXTRA = 2;
`else
   localparam int unsigned SYNC_EXTRA = 0;
`endif

   // Settle timer counts down to zero; the window lasts SETTLE_LOAD+1 cycles.
   localparam int unsigned CNT_W       = 9;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES + SYNC_EXTRA - 1);

   logic gut_s;

`ifdef GATE_ID_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= gut_y;
         sync2_q <= sync1_q;
      end
   end

   assign gut_s = sync2_q;
`else
   assign gut_s = gut_y;
`endif

   state_e            state_q, state_d;
   logic [1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [3:0]        tt_q, tt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              match_q, match_d;
   logic [GATE_W-1:0] gate_id_q, gate_id_d;

   logic              dec_match;
   gate_e             dec_id;

   gate_tt_decode u_decode (
      .tt_i      (tt_q),
      .match_o   (dec_match),
      .gate_id_o (dec_id)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         tt_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
         gate_id_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         tt_q      <= tt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         match_q   <= match_d;
         gate_id_q <= gate_id_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      tt_d      = tt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      match_d   = match_q;
      gate_id_d = gate_id_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_SETTLE;
               idx_d     = 2'd0;
               cnt_d     = SETTLE_LOAD;
               busy_d    = 1'b1;
               tt_d      = '0;
               match_d   = 1'b0;
               gate_id_d = '0;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_SAMPLE: begin
            tt_d[idx_q] = gut_s;
            if (idx_q == 2'd3) begin
               state_d = ST_DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               cnt_d   = SETTLE_LOAD;
               state_d = ST_SETTLE;
            end
         end
         ST_DONE: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            match_d   = dec_match;
            gate_id_d = GATE_W'(dec_id);
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign drive_a     = idx_q[1];
   assign drive_b     = idx_q[0];
   assign busy        = busy_q;
   assign done        = done_q;
   assign match       = match_q;
   assign gate_id     = gate_id_q;
   assign truth_table = tt_q;

endmodule

// File: tb/tb_gate_identifier.sv
module tb_gate_identifier;

   localparam int S = 2;
`ifdef GATE_ID_SYNC_EN
   localparam int SX = 2;
`else
   localparam int SX = 0;
`endif
   localparam int HOLD = S + 1 + SX;
   localparam int LAT  = 4 * HOLD + 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       gut_y;
   logic       drive_a, drive_b;
   logic       busy, done, match;
   logic [2:0] gate_id;
   logic [3:0] truth_table;
   logic [3:0] gut_tt;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   // Gate under test: arbitrary truth table indexed by the driven vector.
   assign gut_y = gut_tt[{drive_a, drive_b}];

   gate_identifier #(.SETTLE_CYCLES(S), .GATE_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .gut_y       (gut_y),
      .drive_a     (drive_a),
      .drive_b     (drive_b),
      .busy        (busy),
      .done        (done),
      .match       (match),
      .gate_id     (gate_id),
      .truth_table (truth_table)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Truth table of library gate g, built by evaluating its boolean expression.
   function automatic logic [3:0] gate_tt(input int g);
      logic [3:0] t;
      logic a, b, y;
      t = '0;
      for (int i = 0; i < 4; i++) begin
         a = 1'((i >> 1) & 1);
         b = 1'(i & 1);
         case (g)
            1: y = a | b;
            2: y = a & b;
            3: y = ~a;
            4: y = ~(a & b);
            5: y = ~(a | b);
            6: y = a ^ b;
            7: y = ~(a ^ b);
            default: y = 1'b0;
         endcase
         t = t | (4'(y) << i);
      end
      return t;
   endfunction

   function automatic int expect_id(input logic [3:0] t);
      for (int g = 1; g <= 7; g++)
         if (gate_tt(g) == t) return g;
      return 0;
   endfunction

   // One full characterisation run with latency, drive sequence and result checks.
   task automatic run_one(input logic [3:0] t, input string tag);
      int  n;
      int  drv_err;
      int  busy_err;
      int  ex;
      logic got;
      logic [1:0] exp_idx;
      gut_tt = t;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 0; drv_err = 0; busy_err = 0; got = 1'b0;
      while (!got && n < 200) begin
         if (done) begin
            got = 1'b1;
         end else begin
            exp_idx = 2'((n / HOLD > 3) ? 3 : n / HOLD);
            if ({drive_a, drive_b} !== exp_idx) drv_err++;
            if (busy !== 1'b1) busy_err++;
            @(posedge clk);
            #1;
            n++;
         end
      end
      ex = expect_id(t);
      check_val({tag, " latency"}, n, LAT);
      check_val({tag, " drives"}, drv_err, 0);
      check_val({tag, " busy_run"}, busy_err, 0);
      check_val({tag, " tt"}, truth_table, t);
      check_val({tag, " id"}, gate_id, ex);
      check_val({tag, " match"}, match, (ex != 0) ? 1 : 0);
      check_val({tag, " busy_done"}, busy, 0);
      @(posedge clk);
      #1;
      check_val({tag, " done_1cyc"}, done, 0);
      repeat (3) @(posedge clk);
      #1;
      check_val({tag, " id_hold"}, gate_id, ex);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      int first;
      int t_last;
      int gaps_bad;
      int cyc;
      logic [3:0] rt;

      rst = 1'b1;
      start = 1'b0;
      gut_tt = 4'b0000;
      #1;
      check_val("reset_outs", {drive_a, drive_b, busy, done, match, gate_id, truth_table}, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int g = 1; g <= 7; g++)
         run_one(gate_tt(g), $sformatf("gate%0d", g));
      run_one(4'b1111, "tie1");
      run_one(4'b1100, "buf_a");
      run_one(4'b0000, "tie0");

      for (int k = 0; k < 12; k++) begin
         rt = 4'($urandom_range(0, 15));
         run_one(rt, $sformatf("rand%0d", k));
      end

      // rst and start together: reset wins
      @(negedge clk);
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      check_val("rst_start_busy", busy, 0);
      check_val("rst_start_outs", {drive_a, drive_b, done, match, gate_id, truth_table}, 0);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;

      // Asynchronous reset in the idx=2 settle window
      gut_tt = gate_tt(6);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2 * HOLD + 1) @(posedge clk);
      #1;
      check_val("mid_pre_drv", {drive_a, drive_b}, 2);
      check_val("mid_pre_tt", truth_table, 4'b0010);
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_rst_outs", {drive_a, drive_b, busy, done, match, gate_id, truth_table}, 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (3 * LAT) begin
         @(posedge clk);
         #1;
         if (done) ndone++;
      end
      check_val("mid_rst_nodone", ndone, 0);
      run_one(gate_tt(6), "after_rst");

      // start re-pulsed while busy is ignored
      gut_tt = gate_tt(2);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      ndone = 0;
      first = -1;
      for (int n = 1; n <= 3 * LAT; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            if (first < 0) first = n;
         end
         start = (n == 4 || n == 9) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      check_val("repulse_ndone", ndone, 1);
      check_val("repulse_lat", first, LAT);
      check_val("repulse_id", gate_id, 2);

      // start held high: back-to-back runs
      gut_tt = gate_tt(7);
      @(negedge clk);
      start = 1'b1;
      ndone = 0;
      t_last = -1;
      gaps_bad = 0;
      cyc = 0;
      while (ndone < 3 && cyc < 10 * LAT) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) begin
            if (t_last >= 0 && (cyc - t_last) != LAT + 1) gaps_bad++;
            t_last = cyc;
            ndone++;
         end
      end
      start = 1'b0;
      check_val("held_ndone", ndone, 3);
      check_val("held_gaps", gaps_bad, 0);
      check_val("held_id", gate_id, 7);
      check_val("held_match", match, 1);
      repeat (2) @(posedge clk);
      #1;
      check_val("held_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
